// File: rtl/isqrt_pkg.sv
// isqrt_pkg: shared widths and FSM state type for the iterative square root
package isqrt_pkg;
    localparam int X_W = 32;
    localparam int Y_W = 16;
    localparam int R_W = 18;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/isqrt_step.sv
// isqrt_step: one restoring digit-by-digit square root iteration on a bit pair
module isqrt_step
    import isqrt_pkg::*;
(
    input  logic [R_W-1:0] rem,
    input  logic [Y_W-1:0] root,
    input  logic [1:0]     bits,
    output logic [R_W-1:0] rem_nxt,
    output logic [Y_W-1:0] root_nxt
);
    logic [R_W+1:0] rem_s;
    logic [R_W+1:0] trial;
    logic           ge;
    always_comb begin
        rem_s    = {rem, bits};
        trial    = {2'b00, root, 2'b01};
        ge       = rem_s >= trial;
        rem_nxt  = ge ? R_W'(rem_s - trial) : rem_s[R_W-1:0];
        root_nxt = {root[Y_W-2:0], ge};
    end
endmodule

// File: rtl/isqrt_iter.sv
// isqrt_iter: fixed-latency integer square root resolving ITERS_PER_CLK root bits per clock
module isqrt_iter
    import isqrt_pkg::*;
#(
    parameter int ITERS_PER_CLK = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           x_vld,
    input  logic [X_W-1:0] x,
    output logic           y_vld,
    output logic [Y_W-1:0] y,
    output logic           busy
);
    localparam int CYC = Y_W / ITERS_PER_CLK;
    state_t         state;
    logic [X_W-1:0] rad;
    logic [R_W-1:0] rem;
    logic [Y_W-1:0] root;
    logic [3:0]     cnt;
    logic [R_W-1:0] rem_c  [ITERS_PER_CLK+1];
    logic [Y_W-1:0] root_c [ITERS_PER_CLK+1];
    assign rem_c[0]  = rem;
    assign root_c[0] = root;
    for (genvar i = 0; i < ITERS_PER_CLK; i++) begin : g_step
        isqrt_step u_step (
            .rem      (rem_c[i]),
            .root     (root_c[i]),
            .bits     (rad[X_W-1-2*i -: 2]),
            .rem_nxt  (rem_c[i+1]),
            .root_nxt (root_c[i+1])
        );
    end
    assign busy = state == CALC;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rad   <= '0;
            rem   <= '0;
            root  <= '0;
            cnt   <= '0;
            y     <= '0;
            y_vld <= 1'b0;
        end else begin
            y_vld <= 1'b0;
            case (state)
                CALC: begin
                    rad  <= rad << (2 * ITERS_PER_CLK);
                    rem  <= rem_c[ITERS_PER_CLK];
                    root <= root_c[ITERS_PER_CLK];
                    cnt  <= cnt + 4'd1;
                    if (cnt == 4'(CYC - 1)) begin
                        state <= DONE;
                        y     <= root_c[ITERS_PER_CLK];
                        y_vld <= 1'b1;
                    end
                end
                default: begin
                    state <= x_vld ? CALC : IDLE;
                    if (x_vld) begin
                        rad  <= x;
                        rem  <= '0;
                        root <= '0;
                        cnt  <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/isqrt_iter.md
ISQRT_ITER -- requirements
Module: isqrt_iter

Interface
REQ-001 The block SHALL have parameter ITERS_PER_CLK, default 1, meaning result bits resolved per clock; legal values are 1, 2, 4, 8, 16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port x_vld, input, 1 bit: request strobe; x is valid this cycle.
REQ-005 The block SHALL have port x, input, 32 bits: unsigned radicand.
REQ-006 The block SHALL have port y_vld, output, 1 bit: single-cycle result strobe.
REQ-007 The block SHALL have port y, output, 16 bits: floor(sqrt(x)) of the accepted request.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a computation is in flight and a new request would be dropped.

Function
REQ-009 The block SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-010 IDLE SHALL go to CALC on x_vld, latching x; otherwise it SHALL stay in IDLE.
REQ-011 CALC SHALL resolve ITERS_PER_CLK root bits per cycle, MSB first, by restoring digit-by-digit square root on bit pairs, then go to DONE once all 16 bits are resolved.
REQ-012 DONE SHALL last exactly one cycle, with y_vld=1 and y equal to the final root.
REQ-013 DONE SHALL go to CALC if x_vld=1 in that same cycle, latching the new x (back-to-back acceptance); otherwise it SHALL go to IDLE.
REQ-014 Latency SHALL be fixed: y_vld is asserted exactly 16/ITERS_PER_CLK + 1 cycles after the acceptance cycle (17 cycles for the default), independent of the value of x.
REQ-015 Acceptance SHALL occur only in IDLE or DONE.
REQ-016 x_vld in CALC SHALL be ignored, with no effect on the in-flight result.
REQ-017 busy SHALL equal (state == CALC).
REQ-018 y SHALL hold its last result value outside DONE; y_vld SHALL be 0 outside DONE.
REQ-019 Internal arithmetic SHALL be exact: remainder 18 bits and root 16 bits, with no truncation.
REQ-020 Results SHALL meet y*y <= x < (y+1)*(y+1) for every 32-bit x, including x = 0 and x = 0xFFFF_FFFF.
REQ-021 Exactly one y_vld pulse SHALL be produced per accepted request, and none for ignored requests.

Reset
REQ-022 While rst=1, the state SHALL be IDLE, y_vld=0, y=0, busy=0, and the remainder, root and radicand registers SHALL be cleared.
REQ-023 rst asserted mid-CALC SHALL abort the computation, and no y_vld SHALL be produced for it.
REQ-024 rst SHALL take priority over x_vld in the same cycle.
REQ-025 x_vld presented in the first cycle after rst deasserts SHALL be accepted normally.

Structure
REQ-026 The shared package isqrt_pkg SHALL hold the constants X_W=32 and Y_W=16 and the state enum type.
REQ-027 A combinational sub-module isqrt_step SHALL implement one bit-pair iteration: inputs rem, root, next two radicand bits; outputs new rem and new root.
REQ-028 isqrt_iter SHALL instantiate isqrt_step ITERS_PER_CLK times in a chain.
REQ-029 The design SHALL use a single instance of the datapath with no pipelining across requests.

Verification
REQ-030 The bench SHALL cover: x=0, 1, 15, 16 sent from IDLE -> y=0, 1, 3, 4 respectively, each with y_vld 17 cycles after acceptance.
REQ-031 The bench SHALL cover: x=0xFFFF_FFFF -> y=0xFFFF; and x=0xFFFE_0001 -> y=0xFFFF; and x=0xFFFE_0000 -> y=0xFFFE.
REQ-032 The bench SHALL cover: x=100 accepted; x_vld with x=49 asserted in DONE -> y=10 pulse, then y=7 exactly 17 cycles later, with no idle cycle in between.
REQ-033 The bench SHALL cover: x=144 accepted; x_vld with x=9 pulsed 5 cycles later (busy=1) -> only y=12 is produced and no second y_vld.
REQ-034 The bench SHALL cover: x=1_000_000 accepted; rst for 1 cycle 8 cycles later -> no y_vld; a following x=81 -> y=9 after 17 cycles.
REQ-035 The bench SHALL cover: a random stream of 10,000 requests at ITERS_PER_CLK of 1, 4 and 16 -> each result matches the software floor(sqrt), with latencies of 17, 5 and 2 respectively.
